// File: rtl/pspi_ss_ctrl_pkg.sv
// Shared PSPI definitions: slave-select sequencer state encoding and timer width.
package pspi_pkg;

  localparam int unsigned SS_TMR_W = 8;

  typedef enum logic [2:0] {
    SS_IDLE   = 3'd0,
    SS_SETUP  = 3'd1,
    SS_ACTIVE = 3'd2,
    SS_HOLD   = 3'd3,
    SS_GAP    = 3'd4
  } ss_state_e;

endpackage

// File: rtl/pspi_ss_ctrl_if.sv
// Command/shift-engine handshake and select pins of the PSPI slave-select controller.
interface pspi_ss_ctrl_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_W      = $clog2(NUM_SLAVES)
);

  logic                  req_valid;
  logic                  req_ready;
  logic [SEL_W-1:0]      req_slave;
  logic                  cont;
  logic                  abort;
  logic                  xfer_start;
  logic                  xfer_done;
  logic [NUM_SLAVES-1:0] ss_n;
  logic                  busy;
  logic                  err;

  // Command logic and shift engine side
  modport master (
    output req_valid, req_slave, cont, abort, xfer_done,
    input  req_ready, xfer_start, ss_n, busy, err
  );

  // Controller side
  modport slave (
    input  req_valid, req_slave, cont, abort, xfer_done,
    output req_ready, xfer_start, ss_n, busy, err
  );

endinterface

// File: rtl/pspi_ss_ctrl_timer.sv
// Loadable 8-bit down-counter shared by the SETUP, HOLD and GAP phases.
module pspi_ss_timer
  import pspi_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SS_TMR_W-1:0] load_val,
  output logic                expired
);

  logic [SS_TMR_W-1:0] count_q;
  logic [SS_TMR_W-1:0] count_d;

  // Parks at zero so expired fires exactly once per load
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - SS_TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == SS_TMR_W'(1));

endmodule

// File: rtl/pspi_ss_ctrl.sv
// Slave-select sequencer: request handshake, setup/hold/gap timing, burst frames,
// abort and out-of-range error reporting around the PSPI shift engine.
module pspi_ss_ctrl
  import pspi_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned GAP_CYC    = 2,
  parameter int unsigned SEL_W      = $clog2(NUM_SLAVES)
) (
  input  logic           clk,
  input  logic           rst,
  pspi_ss_ctrl_if.slave  bus
);

  localparam logic [SS_TMR_W-1:0] SETUP_V   = SS_TMR_W'(SETUP_CYC);
  localparam logic [SS_TMR_W-1:0] HOLD_V    = SS_TMR_W'(HOLD_CYC);
  localparam logic [SS_TMR_W-1:0] GAP_V     = SS_TMR_W'(GAP_CYC);
  localparam logic [SEL_W:0]      IDX_LIMIT = (SEL_W + 1)'(NUM_SLAVES);

  ss_state_e             state_q;
  logic [NUM_SLAVES-1:0] ss_n_q;
  logic                  xfer_start_q;
  logic                  err_q;

  logic                  accept;
  logic                  in_range;
  logic                  tmr_load;
  logic [SS_TMR_W-1:0]   tmr_val;
  logic                  tmr_expired;

  assign accept   = bus.req_valid && (state_q == SS_IDLE);
  assign in_range = ({1'b0, bus.req_slave} < IDX_LIMIT);

  // Timer reload points mirror the FSM transitions below; abort always lands in GAP.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      SS_IDLE: begin
        if (accept && in_range) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_V;
        end
      end
      SS_SETUP: begin
        if (bus.abort) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_V;
        end
      end
      SS_ACTIVE: begin
        if (bus.abort) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_V;
        end else if (bus.xfer_done && !bus.cont) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_V;
        end
      end
      SS_HOLD: begin
        if (bus.abort || tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_V;
        end
      end
      default: ;
    endcase
  end

  pspi_ss_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SS_IDLE;
      ss_n_q       <= '1;
      xfer_start_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      xfer_start_q <= 1'b0;
      err_q        <= 1'b0;
      unique case (state_q)
        SS_IDLE: begin
          if (accept) begin
            if (in_range) begin
              ss_n_q  <= ~(NUM_SLAVES'(1) << bus.req_slave);
              state_q <= SS_SETUP;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SS_SETUP: begin
          if (bus.abort) begin
            ss_n_q  <= '1;
            state_q <= SS_GAP;
          end else if (tmr_expired) begin
            xfer_start_q <= 1'b1;
            state_q      <= SS_ACTIVE;
          end
        end
        SS_ACTIVE: begin
          if (bus.abort) begin
            ss_n_q  <= '1;
            state_q <= SS_GAP;
          end else if (bus.xfer_done) begin
            if (bus.cont) begin
              xfer_start_q <= 1'b1;
            end else begin
              state_q <= SS_HOLD;
            end
          end
        end
        SS_HOLD: begin
          if (bus.abort || tmr_expired) begin
            ss_n_q  <= '1;
            state_q <= SS_GAP;
          end
        end
        SS_GAP: begin
          if (tmr_expired) begin
            state_q <= SS_IDLE;
          end
        end
        default: begin
          ss_n_q  <= '1;
          state_q <= SS_IDLE;
        end
      endcase
    end
  end

  assign bus.ss_n       = ss_n_q;
  assign bus.xfer_start = xfer_start_q;
  assign bus.err        = err_q;
  assign bus.req_ready  = (state_q == SS_IDLE);
  assign bus.busy       = (state_q != SS_IDLE);

  a_one_low: assert property (@(posedge clk) disable iff (rst)
    $countones(~ss_n_q) <= 1);
  a_start_active: assert property (@(posedge clk) disable iff (rst)
    xfer_start_q |-> (state_q == SS_ACTIVE));
  a_err_idle: assert property (@(posedge clk) disable iff (rst)
    err_q |-> (state_q == SS_IDLE));

endmodule

// File: tb/tb_pspi_ss_ctrl.sv
// Bench for pspi_ss_ctrl: five instances with different slave counts and timings,
// randomized frames checked cycle by cycle against a timeline model.
module tb_pspi_ss_ctrl;

  localparam int NDUT = 5;
  localparam int NS [NDUT] = '{4, 3, 2, 5, 8};
  localparam int ST [NDUT] = '{2, 2, 1, 3, 2};
  localparam int HT [NDUT] = '{3, 3, 1, 2, 4};
  localparam int GT [NDUT] = '{2, 2, 1, 4, 3};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NDUT-1:0] v, c, ab, dn;
  logic [NDUT-1:0] rdy, xs, bsy, er;
  logic [7:0]      sl  [NDUT];
  logic [63:0]     ssn [NDUT];

  int errors = 0;
  int checks = 0;

  // Current scenario, cycle numbers relative to the accept cycle (r = 0)
  int sc_slave;
  int sc_nd;
  int sc_abort;
  int sc_done [8];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned N  = NS[g];
    localparam int unsigned SW = $clog2(N);
    pspi_ss_ctrl_if #(.NUM_SLAVES(N)) bus ();
    pspi_ss_ctrl #(
      .NUM_SLAVES (N),
      .SETUP_CYC  (ST[g]),
      .HOLD_CYC   (HT[g]),
      .GAP_CYC    (GT[g])
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.req_valid = v[g];
    assign bus.req_slave = sl[g][SW-1:0];
    assign bus.cont      = c[g];
    assign bus.abort     = ab[g];
    assign bus.xfer_done = dn[g];
    assign rdy[g]        = bus.req_ready;
    assign xs[g]         = bus.xfer_start;
    assign bsy[g]        = bus.busy;
    assign er[g]         = bus.err;
    assign ssn[g]        = {{(64 - N){1'b1}}, bus.ss_n};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    v[k] = 1'b0; c[k] = 1'b0; ab[k] = 1'b0; dn[k] = 1'b0;
  endtask

  task automatic make_frames(input int k, input int nf);
    int d;
    d = 1 + ST[k] + int'($urandom_range(1, 4));
    sc_nd = nf;
    for (int i = 0; i < nf; i++) begin
      sc_done[i] = d;
      d += int'($urandom_range(2, 5));
    end
  endtask

  task automatic drive(input int k, input int r);
    v[k]  = (r == 0);
    sl[k] = 8'(sc_slave);
    ab[k] = (r == sc_abort);
    dn[k] = 1'b0;
    c[k]  = 1'b0;
    for (int i = 0; i < sc_nd; i++) begin
      if (sc_done[i] == r) begin
        dn[k] = 1'b1;
        c[k]  = (i < sc_nd - 1);
      end
    end
  endtask

  // Timeline of the select window, start pulses and ready derived from the timing rules
  function automatic void model(input int k, input int r, output logic [63:0] e_ss,
                                output logic e_xs, output logic e_rdy);
    int sel_end;
    int idle_at;
    int start;
    sel_end = sc_done[sc_nd-1] + HT[k];
    if (sc_abort >= 1 && sc_abort <= sel_end) sel_end = sc_abort;
    idle_at = sel_end + GT[k] + 1;
    e_ss = '1;
    if (r >= 1 && r <= sel_end) e_ss[sc_slave] = 1'b0;
    e_xs = 1'b0;
    for (int i = 0; i < sc_nd; i++) begin
      start = (i == 0) ? 1 + ST[k] : sc_done[i-1] + 1;
      if (r == start && (sc_abort < 1 || start <= sc_abort)) e_xs = 1'b1;
    end
    e_rdy = (r <= 0) || (r >= idle_at);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (ssn[k] !== '1 || xs[k] !== 1'b0 || er[k] !== 1'b0 || bsy[k] !== 1'b0 || rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset dut%0d: ss_n=%h xs=%b err=%b busy=%b rdy=%b, want ss_n all 1 xs=0 err=0 busy=0 rdy=1",
                 k, ssn[k], xs[k], er[k], bsy[k], rdy[k]);
      end
    end
    rst = 1'b0;
    tick();
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (ssn[k] !== '1 || bsy[k] !== 1'b0 || rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release dut%0d: ss_n=%h busy=%b rdy=%b, want all 1/0/1", k, ssn[k], bsy[k], rdy[k]);
      end
    end
  endtask

  task automatic test_basic_frame();
    logic [63:0] e_ss;
    logic        e_xs, e_rdy;
    int          last;
    sc_slave = 2; sc_abort = -1;
    make_frames(0, 1);
    last = sc_done[0] + HT[0] + GT[0] + 2;
    for (int r = 0; r <= last; r++) begin
      drive(0, r);
      model(0, r, e_ss, e_xs, e_rdy);
      checks++;
      if (ssn[0] !== e_ss || xs[0] !== e_xs || rdy[0] !== e_rdy || bsy[0] !== !e_rdy) begin
        errors++;
        $display("FAIL basic r=%0d D=%0d: ss_n=%h xs=%b rdy=%b busy=%b, want ss_n=%h xs=%b rdy=%b",
                 r, sc_done[0], ssn[0][3:0], xs[0], rdy[0], bsy[0], e_ss[3:0], e_xs, e_rdy);
      end
      tick();
    end
    idle(0);
  endtask

  task automatic test_burst();
    logic [63:0] e_ss;
    logic        e_xs, e_rdy;
    int          last, starts;
    sc_slave = int'($urandom_range(0, 3)); sc_abort = -1; starts = 0;
    make_frames(0, 3);
    last = sc_done[2] + HT[0] + GT[0] + 2;
    for (int r = 0; r <= last; r++) begin
      drive(0, r);
      model(0, r, e_ss, e_xs, e_rdy);
      if (xs[0] === 1'b1) starts++;
      checks++;
      if (ssn[0] !== e_ss || xs[0] !== e_xs || rdy[0] !== e_rdy) begin
        errors++;
        $display("FAIL burst r=%0d slave=%0d: ss_n=%h xs=%b rdy=%b, want ss_n=%h xs=%b rdy=%b",
                 r, sc_slave, ssn[0][3:0], xs[0], rdy[0], e_ss[3:0], e_xs, e_rdy);
      end
      tick();
    end
    idle(0);
    checks++;
    if (starts !== 3) begin
      errors++;
      $display("FAIL burst_start_count: got %0d pulses, want 3", starts);
    end
  endtask

  task automatic test_error();
    v[1] = 1'b1; sl[1] = 8'd3;
    v[3] = 1'b1; sl[3] = 8'($urandom_range(5, 7));
    tick();
    v[1] = 1'b0; v[3] = 1'b0;
    for (int k = 1; k <= 3; k += 2) begin
      checks++;
      if (er[k] !== 1'b1 || ssn[k] !== '1 || bsy[k] !== 1'b0 || rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL error_pulse dut%0d idx=%0d: err=%b ss_n=%h busy=%b rdy=%b, want 1/all 1/0/1",
                 k, sl[k], er[k], ssn[k], bsy[k], rdy[k]);
      end
    end
    tick();
    for (int k = 1; k <= 3; k += 2) begin
      checks++;
      if (er[k] !== 1'b0 || ssn[k] !== '1 || rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL error_after dut%0d: err=%b ss_n=%h rdy=%b, want 0/all 1/1", k, er[k], ssn[k], rdy[k]);
      end
    end
  endtask

  task automatic test_abort();
    logic [63:0] e_ss;
    logic        e_xs, e_rdy;
    int          last;
    for (int it = 0; it < 5; it++) begin
      sc_slave = int'($urandom_range(0, 3));
      if (it == 0) begin
        // abort coincides with a burst xfer_done that asks to continue
        make_frames(0, 2);
        sc_abort = sc_done[0];
      end else begin
        make_frames(0, 1);
        sc_abort = int'($urandom_range(1, sc_done[0] + HT[0] + GT[0]));
      end
      last = sc_done[sc_nd-1] + HT[0] + GT[0] + 2;
      for (int r = 0; r <= last; r++) begin
        drive(0, r);
        model(0, r, e_ss, e_xs, e_rdy);
        checks++;
        if (ssn[0] !== e_ss || xs[0] !== e_xs || rdy[0] !== e_rdy) begin
          errors++;
          $display("FAIL abort it=%0d r=%0d A=%0d: ss_n=%h xs=%b rdy=%b, want ss_n=%h xs=%b rdy=%b",
                   it, r, sc_abort, ssn[0][3:0], xs[0], rdy[0], e_ss[3:0], e_xs, e_rdy);
        end
        tick();
      end
      idle(0);
    end
    sc_abort = -1;
  endtask

  task automatic test_reset_mid_hold();
    int          rpos, nslave;
    logic [63:0] e_ss;
    sc_slave = int'($urandom_range(0, 3)); sc_abort = -1;
    make_frames(0, 1);
    rpos = sc_done[0] + int'($urandom_range(1, HT[0]));
    for (int r = 0; r < rpos; r++) begin
      drive(0, r);
      tick();
    end
    idle(0);
    e_ss = '1; e_ss[sc_slave] = 1'b0;
    checks++;
    if (ssn[0] !== e_ss || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL hold_before_reset: ss_n=%h rdy=%b, want ss_n=%h rdy=0", ssn[0][3:0], rdy[0], e_ss[3:0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ssn[0] !== '1 || xs[0] !== 1'b0 || er[0] !== 1'b0 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_hold: ss_n=%h xs=%b err=%b busy=%b rdy=%b, want all 1/0/0/0/1",
               ssn[0][3:0], xs[0], er[0], bsy[0], rdy[0]);
    end
    nslave = int'($urandom_range(0, 3));
    v[0] = 1'b1; sl[0] = 8'(nslave);
    tick();
    v[0] = 1'b0;
    e_ss = '1; e_ss[nslave] = 1'b0;
    checks++;
    if (ssn[0] !== e_ss || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL accept_after_reset: ss_n=%h rdy=%b, want ss_n=%h rdy=0", ssn[0][3:0], rdy[0], e_ss[3:0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sweep();
    logic [63:0] e_ss;
    logic        e_xs, e_rdy;
    int          last;
    sc_abort = -1;
    for (int k = 2; k < NDUT; k++) begin
      for (int s = 0; s < NS[k]; s++) begin
        sc_slave = s;
        make_frames(k, int'($urandom_range(1, 3)));
        last = sc_done[sc_nd-1] + HT[k] + GT[k] + 2;
        for (int r = 0; r <= last; r++) begin
          drive(k, r);
          model(k, r, e_ss, e_xs, e_rdy);
          checks++;
          if (ssn[k] !== e_ss || xs[k] !== e_xs || rdy[k] !== e_rdy || er[k] !== 1'b0) begin
            errors++;
            $display("FAIL sweep N=%0d slave=%0d r=%0d: ss_n=%h xs=%b rdy=%b err=%b, want ss_n=%h xs=%b rdy=%b err=0",
                     NS[k], s, r, ssn[k][7:0], xs[k], rdy[k], er[k], e_ss[7:0], e_xs, e_rdy);
          end
          tick();
        end
        idle(k);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    v = '0; c = '0; ab = '0; dn = '0;
    for (int k = 0; k < NDUT; k++) sl[k] = '0;
    sc_slave = 0; sc_nd = 1; sc_abort = -1;
    for (int i = 0; i < 8; i++) sc_done[i] = 0;
    repeat (3) tick();
    test_reset();
    test_basic_frame();
    test_burst();
    test_error();
    test_abort();
    test_reset_mid_hold();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
